// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver state encoding, frame width and the
// default bit period used by both uart_tx and spart_rx.
package spart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int BAUD_DEFAULT = 2604;  // 50 MHz / 19200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchroniser for a single asynchronous input. RESET_VAL sets the
// value both flops take in reset; for a UART line this is 1 (idle).
module spart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops before anyone looks at it.
  // NOTE: clocked state uses non-blocking assignments so that meta and q both
  // update from their pre-edge values; blocking here would collapse the two
  // stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spart_rx.sv
// SPART serial receiver: 8N1 async frame on rx -> byte on rx_data with a sticky
// rdy flag cleared by clr_rdy. Each bit is sampled at its centre by a
// down-counting baud timer started from the detected start edge.
// Define SPART_RX_PARITY_EN for 8E1 frames and the parity_err output.
module spart_rx
  import spart_pkg::*;
#(
  parameter int BAUD_CLKS = BAUD_DEFAULT  // clk cycles per bit, >= 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
`ifdef SPART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frm_err
);

  localparam int              CW        = $clog2(BAUD_CLKS);
  localparam logic [CW-1:0]   HALF_LOAD = CW'(BAUD_CLKS / 2 - 1);
  localparam logic [CW-1:0]   FULL_LOAD = CW'(BAUD_CLKS - 1);

  rx_state_t         state, state_nxt;
  logic              rx_s, rx_s_q;
  logic [CW-1:0]     baud_cnt;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              expiry;
  logic              start_det, load_half, load_full, shift_en, set_rdy, set_frm;
`ifdef SPART_RX_PARITY_EN
  logic              par_chk;
`endif

  spart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign expiry = (baud_cnt == '0) && (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath strobes.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    set_rdy   = 1'b0;
    set_frm   = 1'b0;
`ifdef SPART_RX_PARITY_EN
    par_chk   = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Only a 1->0 transition starts a frame, so a held-low line is ignored.
        if (rx_s_q && !rx_s) begin
          state_nxt = START;
          start_det = 1'b1;
          load_half = 1'b1;
        end
      end
      START: begin
        if (expiry) begin
          if (!rx_s) begin
            state_nxt = DATA;
            load_full = 1'b1;
          end else begin
            state_nxt = IDLE;  // too short to be a start bit
          end
        end
      end
      DATA: begin
        if (expiry) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef SPART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef SPART_RX_PARITY_EN
      PARITY: begin
        if (expiry) begin
          par_chk   = 1'b1;
          load_full = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (expiry) begin
          if (rx_s) set_rdy = 1'b1;
          else      set_frm = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Baud timer, bit counter, shift register and the sticky output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s_q    <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_s_q <= rx_s;

      if (load_half)                            baud_cnt <= HALF_LOAD;
      else if (load_full)                       baud_cnt <= FULL_LOAD;
      else if (state != IDLE && baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;

      if (state == START) bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;

      // LSB arrives first, so each new bit enters at the top and moves down.
      if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};

      // A completing good frame wins over a simultaneous clear request.
      if (set_rdy) begin
        rx_data <= shift_reg;
        rdy     <= 1'b1;
      end else if (start_det || clr_rdy) begin
        rdy <= 1'b0;
      end

      if (start_det)    frm_err <= 1'b0;
      else if (set_frm) frm_err <= 1'b1;

`ifdef SPART_RX_PARITY_EN
      // Even parity: data plus parity bit must XOR to zero.
      if (start_det)                            parity_err <= 1'b0;
      else if (par_chk && ^{shift_reg, rx_s})   parity_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx. Two instances share clk/rst: one at the
// production bit period (used for the latency frame) and one at a short bit
// period for the functional scenarios. Expected bytes are pushed to a queue
// when a frame is driven and popped when rdy shows the byte has arrived.
module tb_spart_rx;
  import spart_pkg::*;

  localparam int SLOW_B = BAUD_DEFAULT;
  localparam int FAST_B = 16;
`ifdef SPART_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_slow = 1'b1, rx_fast = 1'b1;
  logic       clr_slow = 1'b0, clr_fast = 1'b0;
  logic [7:0] data_slow, data_fast;
  logic       rdy_slow, rdy_fast, frm_slow, frm_fast;
`ifdef SPART_RX_PARITY_EN
  logic       par_slow, par_fast;
  logic       par_flip_tb = 1'b0;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;

  always #5 clk = ~clk;

  spart_rx #(.BAUD_CLKS(SLOW_B)) dut_slow (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_slow),
    .clr_rdy    (clr_slow),
    .rx_data    (data_slow),
    .rdy        (rdy_slow),
`ifdef SPART_RX_PARITY_EN
    .parity_err (par_slow),
`endif
    .frm_err    (frm_slow)
  );

  spart_rx #(.BAUD_CLKS(FAST_B)) dut_fast (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_fast),
    .clr_rdy    (clr_fast),
    .rx_data    (data_fast),
    .rdy        (rdy_fast),
`ifdef SPART_RX_PARITY_EN
    .parity_err (par_fast),
`endif
    .frm_err    (frm_fast)
  );

  task automatic set_line(input bit fast, input logic v);
    if (fast) rx_fast = v;
    else      rx_slow = v;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame (start, data LSB first, [even parity], stop) on the chosen
  // line. rise_at is the cycle, counted from the start edge, at which rdy was
  // first seen rising (-1 if it never rose).
  task automatic send_frame(input bit fast, input logic [7:0] d,
                            input logic stop, output int rise_at);
    logic [10:0] bits;
    int          b;
    int          cyc;
    logic        prev, cur;
    b       = fast ? FAST_B : SLOW_B;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) bits[1 + i] = d[i];
`ifdef SPART_RX_PARITY_EN
    bits[9]  = (^d) ^ par_flip_tb;
    bits[10] = stop;
`else
    bits[9]  = stop;
`endif
    rise_at = -1;
    cyc     = 0;
    prev    = fast ? rdy_fast : rdy_slow;
    for (int k = 0; k < FRAME_BITS; k++) begin
      set_line(fast, bits[k]);
      for (int c = 0; c < b; c++) begin
        @(posedge clk);
        #1;
        cyc++;
        cur = fast ? rdy_fast : rdy_slow;
        if (cur && !prev && rise_at < 0) rise_at = cyc;
        prev = cur;
      end
    end
    set_line(fast, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    checks++; if (data_slow !== 8'h00) begin errors++; $display("FAIL reset_slow_data: got %h want 00", data_slow); end
    checks++; if (rdy_slow !== 1'b0)   begin errors++; $display("FAIL reset_slow_rdy: got %b want 0", rdy_slow); end
    checks++; if (frm_slow !== 1'b0)   begin errors++; $display("FAIL reset_slow_frm: got %b want 0", frm_slow); end
    checks++; if (data_fast !== 8'h00) begin errors++; $display("FAIL reset_fast_data: got %h want 00", data_fast); end
    checks++; if (rdy_fast !== 1'b0)   begin errors++; $display("FAIL reset_fast_rdy: got %b want 0", rdy_fast); end
    checks++; if (frm_fast !== 1'b0)   begin errors++; $display("FAIL reset_fast_frm: got %b want 0", frm_fast); end
`ifdef SPART_RX_PARITY_EN
    checks++; if (par_fast !== 1'b0)   begin errors++; $display("FAIL reset_fast_par: got %b want 0", par_fast); end
`endif
  endtask

  // Full-rate frame: start edge takes 2 sync clks plus 1 edge-detect clk, then
  // half a bit to the start centre and one bit time per following sample.
  task automatic test_latency;
    int rise;
    int exp_lat;
    exp_lat = 3 + SLOW_B / 2 + (FRAME_BITS - 1) * SLOW_B;
    exp_q.push_back(8'hCC);
    send_frame(1'b0, 8'hCC, 1'b1, rise);
    checks++; if (rise < exp_lat - 2 || rise > exp_lat + 2) begin errors++; $display("FAIL latency_cc: got %0d clks want %0d", rise, exp_lat); end
    checks++; if (rdy_slow !== 1'b1) begin errors++; $display("FAIL latency_rdy: got %b want 1", rdy_slow); end
    exp_byte = exp_q.pop_front();
    checks++; if (data_slow !== exp_byte) begin errors++; $display("FAIL latency_data: got %h want %h", data_slow, exp_byte); end
    checks++; if (frm_slow !== 1'b0) begin errors++; $display("FAIL latency_frm: got %b want 0", frm_slow); end
  endtask

  task automatic test_clr_rdy;
    int rise;
    exp_q.push_back(8'hCC);
    send_frame(1'b1, 8'hCC, 1'b1, rise);
    exp_byte = exp_q.pop_front();
    checks++; if (rdy_fast !== 1'b1 || data_fast !== exp_byte) begin errors++; $display("FAIL clr_first: got rdy=%b data=%h want rdy=1 data=%h", rdy_fast, data_fast, exp_byte); end
    clr_fast = 1'b1; tick(1); clr_fast = 1'b0;
    checks++; if (rdy_fast !== 1'b0) begin errors++; $display("FAIL clr_clears: got %b want 0", rdy_fast); end
    clr_fast = 1'b1; tick(1); clr_fast = 1'b0;
    checks++; if (rdy_fast !== 1'b0 || data_fast !== 8'hCC) begin errors++; $display("FAIL clr_idle: got rdy=%b data=%h want rdy=0 data=cc", rdy_fast, data_fast); end
    exp_q.push_back(8'hA7);
    send_frame(1'b1, 8'hA7, 1'b1, rise);
    exp_byte = exp_q.pop_front();
    checks++; if (rdy_fast !== 1'b1 || data_fast !== exp_byte) begin errors++; $display("FAIL clr_second: got rdy=%b data=%h want rdy=1 data=%h", rdy_fast, data_fast, exp_byte); end
    // clr_rdy held through a whole frame: the set must still show for a cycle.
    clr_fast = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(1'b1, 8'h5A, 1'b1, rise);
    tick(1);
    clr_fast = 1'b0;
    exp_byte = exp_q.pop_front();
    checks++; if (rise < 0) begin errors++; $display("FAIL set_wins: got no rdy pulse want one"); end
    checks++; if (data_fast !== exp_byte || rdy_fast !== 1'b0) begin errors++; $display("FAIL set_wins_after: got rdy=%b data=%h want rdy=0 data=%h", rdy_fast, data_fast, exp_byte); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat [4];
    int rise;
    pat = '{8'h00, 8'hFF, 8'h81, 8'h3E};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pat[i]);
      send_frame(1'b1, pat[i], 1'b1, rise);
      exp_byte = exp_q.pop_front();
      checks++; if (rdy_fast !== 1'b1 || data_fast !== exp_byte) begin errors++; $display("FAIL b2b_%0d: got rdy=%b data=%h want rdy=1 data=%h", i, rdy_fast, data_fast, exp_byte); end
    end
  endtask

  task automatic test_glitch;
    int rise;
    // Low for a quarter bit: long enough to be seen, short of the half-bit sample.
    rx_fast = 1'b0; tick(FAST_B / 4); rx_fast = 1'b1;
    tick(2 * FAST_B);
    checks++; if (rdy_fast !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b want 0", rdy_fast); end
    checks++; if (data_fast !== 8'h3E || frm_fast !== 1'b0) begin errors++; $display("FAIL glitch_hold: got data=%h frm=%b want data=3e frm=0", data_fast, frm_fast); end
    exp_q.push_back(8'hC3);
    send_frame(1'b1, 8'hC3, 1'b1, rise);
    exp_byte = exp_q.pop_front();
    checks++; if (rdy_fast !== 1'b1 || data_fast !== exp_byte) begin errors++; $display("FAIL glitch_next: got rdy=%b data=%h want rdy=1 data=%h", rdy_fast, data_fast, exp_byte); end
  endtask

  task automatic test_frame_err;
    int rise;
    send_frame(1'b1, 8'h55, 1'b0, rise);
    rx_fast = 1'b0;  // keep the line in break after the bad stop bit
    tick(2);
    checks++; if (frm_fast !== 1'b1 || rdy_fast !== 1'b0) begin errors++; $display("FAIL frm_set: got frm=%b rdy=%b want frm=1 rdy=0", frm_fast, rdy_fast); end
    checks++; if (data_fast !== 8'hC3) begin errors++; $display("FAIL frm_data: got %h want c3", data_fast); end
    tick(3 * FAST_B);
    checks++; if (frm_fast !== 1'b1) begin errors++; $display("FAIL break_retrigger: got frm=%b want 1", frm_fast); end
    rx_fast = 1'b1;
    tick(2 * FAST_B);
    exp_q.push_back(8'h96);
    send_frame(1'b1, 8'h96, 1'b1, rise);
    exp_byte = exp_q.pop_front();
    checks++; if (rdy_fast !== 1'b1 || data_fast !== exp_byte || frm_fast !== 1'b0) begin errors++; $display("FAIL frm_recover: got rdy=%b data=%h frm=%b want 1 %h 0", rdy_fast, data_fast, frm_fast, exp_byte); end
  endtask

  task automatic test_reset_mid;
    int rise;
    rx_fast = 1'b0; tick(FAST_B);
    rx_fast = 1'b1; tick(4 * FAST_B + FAST_B / 2);
    #2 rst = 1'b1;
    #1;
    checks++; if (data_fast !== 8'h00 || rdy_fast !== 1'b0 || frm_fast !== 1'b0) begin errors++; $display("FAIL rst_mid: got data=%h rdy=%b frm=%b want 00 0 0", data_fast, rdy_fast, frm_fast); end
    tick(2);
    rst = 1'b0;
    tick(2 * FAST_B);
    exp_q.push_back(8'h3C);
    send_frame(1'b1, 8'h3C, 1'b1, rise);
    exp_byte = exp_q.pop_front();
    checks++; if (rdy_fast !== 1'b1 || data_fast !== exp_byte) begin errors++; $display("FAIL rst_next: got rdy=%b data=%h want rdy=1 data=%h", rdy_fast, data_fast, exp_byte); end
  endtask

`ifdef SPART_RX_PARITY_EN
  task automatic test_parity;
    int rise;
    par_flip_tb = 1'b1;
    exp_q.push_back(8'h01);
    send_frame(1'b1, 8'h01, 1'b1, rise);
    par_flip_tb = 1'b0;
    exp_byte = exp_q.pop_front();
    checks++; if (par_fast !== 1'b1 || rdy_fast !== 1'b1 || data_fast !== exp_byte) begin errors++; $display("FAIL parity_bad: got perr=%b rdy=%b data=%h want 1 1 %h", par_fast, rdy_fast, data_fast, exp_byte); end
    exp_q.push_back(8'h80);
    send_frame(1'b1, 8'h80, 1'b1, rise);
    exp_byte = exp_q.pop_front();
    checks++; if (par_fast !== 1'b0 || rdy_fast !== 1'b1 || data_fast !== exp_byte) begin errors++; $display("FAIL parity_good: got perr=%b rdy=%b data=%h want 0 1 %h", par_fast, rdy_fast, data_fast, exp_byte); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_clr_rdy();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef SPART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
